// File: rtl/spi_rb_bridge.sv
// SPI mode-0 slave to register-bank bridge, all SPI pins oversampled in clk.
// Optional: define SPI_RB_AUTOINC_EN to step the address after each data byte.
module spi_rb_bridge #(
    parameter int ADR_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_sclk,
    input  logic                spi_csn,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic [ADR_BITS-1:0] address,
    output logic [7:0]          data_write_in,
    input  logic [7:0]          data_read_out,
    output logic                reg_en,
    output logic                write_en,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        ADDR,
        DATA
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
    logic [SYNC_STAGES:0]   flush;
    logic sclk_s, csn_s, mosi_s;
    logic sclk_d, csn_d;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic armed;

    logic [2:0] bitcnt;
    logic [7:0] shift_in;
    logic       byte_done;

    logic       wr, wr_n;
    logic       addr_set, data_adv, write_pulse;
    logic       reload_req, addr_chg, tx_load;
    logic [7:0] tx_shift;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d & ~csn_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~csn_s;
    assign csn_fall  = ~csn_s & csn_d;
    assign csn_rise  = csn_s & ~csn_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            // csn_sync holds its reset value until flushed; only trust it after
            if (flush[SYNC_STAGES] && csn_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt    <= 3'd0;
            shift_in  <= 8'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (csn_fall) begin
                bitcnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_in  <= {shift_in[6:0], mosi_s};
                bitcnt    <= bitcnt + 3'd1;
                byte_done <= (bitcnt == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        wr_n        = wr;
        addr_set    = 1'b0;
        data_adv    = 1'b0;
        write_pulse = 1'b0;
        if (csn_rise) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (csn_fall && armed) state_n = CMD;
                CMD: if (byte_done) begin
                    state_n = ADDR;
                    wr_n    = shift_in[7];
                end
                ADDR: if (byte_done) begin
                    state_n  = DATA;
                    addr_set = 1'b1;
                end
                DATA: if (byte_done) begin
                    data_adv    = 1'b1;
                    write_pulse = wr;
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef SPI_RB_AUTOINC_EN
    // step one cycle after the strobe so address is stable while write_en is high
    logic addr_step;

    always_ff @(posedge clk) begin
        if (reset)
            addr_step <= 1'b0;
        else
            addr_step <= data_adv;
    end

    assign reload_req = addr_set | addr_step;
`else
    assign reload_req = addr_set | data_adv;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr            <= 1'b0;
            address       <= '0;
            data_write_in <= 8'd0;
            write_en      <= 1'b0;
            reg_en        <= 1'b0;
            addr_chg      <= 1'b0;
            tx_load       <= 1'b0;
            tx_shift      <= 8'd0;
        end else begin
            wr       <= wr_n;
            write_en <= write_pulse;
            if (write_pulse)
                data_write_in <= shift_in;
            if (addr_set)
                address <= shift_in[ADR_BITS-1:0];
`ifdef SPI_RB_AUTOINC_EN
            else if (addr_step)
                address <= address + ADR_BITS'(1);
`endif
            if (state_n == IDLE)
                reg_en <= 1'b0;
            else if (addr_set)
                reg_en <= 1'b1;
            // bank registers the new address, then one cycle of margin
            addr_chg <= reload_req;
            tx_load  <= addr_chg;
            if (tx_load)
                tx_shift <= data_read_out;
            else if (sclk_fall && bitcnt != 3'd0)
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    assign busy        = (state != IDLE);
    assign spi_miso_oe = ~csn_s & busy;
    assign spi_miso    = (state == DATA && !wr) ? tx_shift[7] : 1'b0;

endmodule

// File: doc/spi_rb_bridge.md
Name: spi_rb_bridge

Overview:
SPI slave (mode 0) that turns serial frames from the external host into register-bank bus cycles. It drives address, data_write_in, write_en and reg_en of the downstream register bank and serialises that bank's registered data_read_out back onto MISO. All SPI inputs are oversampled in the clk domain; no logic is clocked by SCLK.

Parameters:
ADR_BITS, 8, register-bank address width; also the width of the frame's address byte field (ADR_BITS <= 8)
SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_csn and spi_mosi (>= 2)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous reset, active-high
spi_sclk  in  1  SPI clock, asynchronous to clk
spi_csn  in  1  SPI chip select, active-low
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out
spi_miso_oe  out  1  MISO pad output enable
address  out  ADR_BITS  register address to the bank
data_write_in  out  8  write data to the bank
data_read_out  in  8  bank read data, registered, valid 1 clk after address
reg_en  out  1  high while a valid address is held in the current frame
write_en  out  1  single-cycle write strobe
busy  out  1  high while the frame is active (state != IDLE)

Behaviour:
- Only one clock (clk). Reset is synchronous and active-high.
- Reset values: address=0, data_write_in=0, write_en=0, reg_en=0, spi_miso=0, spi_miso_oe=0, busy=0, state=IDLE. Synchroniser flops reset csn=1, sclk=0, mosi=0.
- Edge detection runs on the synchronised signals. sclk_rise/sclk_fall/csn_fall/csn_rise are each 1-cycle pulses.
- Timing requirement: clk >= 16x SCLK frequency.
- Frame format, MSB first: byte0 = command {wr, 7'b0}, wr=1 means write; byte1 = address, with the low ADR_BITS bits used; byte2..N = data.
- Bit counter bitcnt[2:0]:
  - Cleared on csn_fall.
  - Increments on sclk_rise, sampling mosi into shift_in.
  - After the 8th rise it wraps to 0 and asserts byte_done for the next cycle.
- States:
  - IDLE -> CMD on csn_fall, only if armed. armed sets when synchronised csn is high and clears after reset. A frame already in progress at reset release is therefore ignored until csn deasserts.
  - CMD -> ADDR on byte_done; latches wr. Reserved bits are ignored.
  - ADDR -> DATA on byte_done. address <= byte; reg_en <= 1.
  - DATA -> DATA on each byte_done.
    - Write: data_write_in <= byte and write_en=1 for exactly the same cycle; address is stable during the strobe.
    - Read: no write_en, ever.
  - Any state -> IDLE on csn_rise. A partial byte is discarded with no write_en. reg_en drops to 0. address and data_write_in hold their values.
- Read path:
  - tx_load fires 2 clk after address updates (1 clk for the bank register, 1 clk margin). It sets tx_shift <= data_read_out.
  - On sclk_fall, tx_shift shifts left only when bitcnt != 0, so the loaded MSB is presented on the first falling edge of the byte.
  - spi_miso = tx_shift[7] in the DATA state of a read frame; 0 otherwise.
  - spi_miso_oe = armed frame active, i.e. synchronised csn low and busy.
- Address update for bytes after the first data byte is per the optional feature. Address arithmetic is modulo 2^ADR_BITS (0xFF+1 -> 0x00 for ADR_BITS=8).
- Simultaneous events:
  - csn_rise in the same cycle as byte_done: byte_done is discarded, no write.
  - sclk edges while csn is high are ignored.

Optional Feature:
SPI_RB_AUTOINC_EN
- Defined: after each DATA byte_done (read or write), address increments by 1 with wrap-around. For reads, the next byte is reloaded via tx_load 2 clk later, so burst read/write walks consecutive registers.
- Undefined: address stays fixed for the whole frame. Repeated data bytes rewrite, or re-read, the same register.

Test Plan:
- Reset held with csn low, then released and the frame continues -> no write_en, no reg_en until csn goes high then low again.
- Write frame 0x80,0x01,0x5A -> one write_en pulse with address=0x01, data_write_in=0x5A; reg_en high from after the address byte to csn_rise.
- Read frame 0x00,0x18,0x00 with the bank returning 0x40 at addr 0x18 -> MISO shifts out 0x40 MSB first; spi_miso=0 during bytes 0-1.
- Burst write 0x80,0xFF,0x11,0x22 with SPI_RB_AUTOINC_EN -> writes 0x11@0xFF then 0x22@0x00 (wrap). Without the macro -> both writes go to 0xFF.
- csn deasserted after 5 bits of a data byte -> no write_en; state=IDLE, busy=0; the next full frame works normally.
- Burst read 0x00,0x18 plus 3 data bytes with SPI_RB_AUTOINC_EN and bank values 0x40,0x18,0x53 -> MISO bytes 0x40,0x18,0x53 with no bit slip at 16x oversampling.
